// File: rtl/agg_frame_arbiter_if.sv
// rtl/agg_frame_arbiter_if.sv - source/aggregator handshake bundle for agg_frame_arbiter
// Purpose: groups the per-source request streams and the single aggregator stream.
// Signals:
//   req_valid [NUM_SRC]         per-source data valid
//   req_data  [NUM_SRC*DATA_W]  per-source data, source i at [i*DATA_W +: DATA_W]
//   req_rdy   [NUM_SRC]         per-source ready, at most one bit set
//   agg_valid / agg_data        towards aggregator valid_src / data_in
//   agg_rdy                     from aggregator rdy_src
// Modports: slave = arbiter side, master = sources plus aggregator side.
interface agg_frame_arbiter_if #(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 16
);
   logic [NUM_SRC-1:0]        req_valid;
   logic [NUM_SRC*DATA_W-1:0] req_data;
   logic [NUM_SRC-1:0]        req_rdy;
   logic                      agg_valid;
   logic [DATA_W-1:0]         agg_data;
   logic                      agg_rdy;

   modport slave (
      input  req_valid, req_data, agg_rdy,
      output req_rdy, agg_valid, agg_data
   );

   modport master (
      output req_valid, req_data, agg_rdy,
      input  req_rdy, agg_valid, agg_data
   );
endinterface

// File: rtl/agg_frame_arbiter.sv
// rtl/agg_frame_arbiter.sv - frame-locked round-robin arbiter in front of a 16-to-23 bit aggregator
// Purpose: grants one source at a time for exactly FRAME_BEATS accepted beats so the
//          aggregator's residual bit buffer is empty whenever the grant changes.
// Ports:
//   clk           single clock, rising edge
//   rst           asynchronous active-low reset
//   bus           handshake bundle (slave modport): source requests and aggregator stream
//   grant_id      index of the current or last granted source
//   frame_active  high while a frame is in progress
//   frame_done    one-cycle pulse in the cycle after the last beat of a frame
module agg_frame_arbiter #(
   parameter int  NUM_SRC     = 4,
   parameter int  DATA_W      = 16,
   parameter int  FRAME_BEATS = 23,
   localparam int ID_W        = $clog2(NUM_SRC),
   localparam int CNT_W       = $clog2(FRAME_BEATS)
) (
   input  logic                 clk,
   input  logic                 rst,
   agg_frame_arbiter_if.slave   bus,
   output logic [ID_W-1:0]      grant_id,
   output logic                 frame_active,
   output logic                 frame_done
);

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [CNT_W-1:0]  beat_cnt;
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   cand_id;
   logic              found;
   logic              accept;
   logic              last_beat;
   logic [ID_W-1:0]   next_ptr;

   // Round-robin scan starting at ptr; the first valid source in wrap order wins.
   always_comb begin
      winner  = '0;
      found   = 1'b0;
      cand_id = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand_id = ID_W'((int'(ptr) + k) % NUM_SRC);
         if (!found && bus.req_valid[cand_id]) begin
            found  = 1'b1;
            winner = cand_id;
         end
      end
   end

   // Datapath is a pure mux off the registered grant, so ready tracks agg_rdy in the same cycle.
   always_comb begin
      bus.req_rdy   = '0;
      bus.agg_valid = 1'b0;
      bus.agg_data  = '0;
      if (state == XFER) begin
         bus.agg_valid         = bus.req_valid[grant_id];
         bus.agg_data          = bus.req_data[int'(grant_id)*DATA_W +: DATA_W];
         bus.req_rdy[grant_id] = bus.agg_rdy;
      end
   end

   assign accept    = (state == XFER) && bus.agg_valid && bus.agg_rdy;
   assign last_beat = (beat_cnt == CNT_W'(FRAME_BEATS - 1));
   // The source that just finished becomes the last candidate of the next scan.
   assign next_ptr  = (grant_id == ID_W'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         ptr          <= '0;
         grant_id     <= '0;
         beat_cnt     <= '0;
         frame_active <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  grant_id     <= winner;
                  beat_cnt     <= '0;
                  frame_active <= 1'b1;
                  state        <= XFER;
               end
            end
            XFER: begin
               // No timeout or preemption: an idle granted source simply holds the frame open.
               if (accept) begin
                  if (last_beat) begin
                     state        <= IDLE;
                     frame_active <= 1'b0;
                     frame_done   <= 1'b1;
                     ptr          <= next_ptr;
                     beat_cnt     <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_agg_frame_arbiter.sv
// tb/tb_agg_frame_arbiter.sv - scoreboard bench for agg_frame_arbiter
module tb_agg_frame_arbiter;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int FB = 23;

   typedef struct packed {
      logic          fa;
      logic          fd;
      logic [1:0]    gid;
      logic [N-1:0]  rdy;
      logic          av;
      logic [W-1:0]  dat;
   } cyc_t;

   typedef struct packed {
      logic [1:0]    src;
      logic [W-1:0]  dat;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   agg_frame_arbiter_if #(.NUM_SRC(N), .DATA_W(W)) bus ();
   logic [1:0] grant_id;
   logic       frame_active;
   logic       frame_done;

   agg_frame_arbiter #(.NUM_SRC(N), .DATA_W(W), .FRAME_BEATS(FB)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .grant_id     (grant_id),
      .frame_active (frame_active),
      .frame_done   (frame_done)
   );

   int total = 0;
   int bad   = 0;

   cyc_t  cyc_q[$];
   beat_t beat_q[$];

   // Reference model: who owns the aggregator, how many beats it has delivered, scan start.
   int m_busy, m_owner, m_beats, m_ptr, m_done;
   int seq[N];

   logic [N-1:0] v_mask;
   int v_pct, r_pct, rdy_force;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Expected outputs for the current cycle from the current model state, then advance the model.
   task automatic model_step();
      cyc_t e;
      logic [W-1:0] d;
      d = '0;
      if (m_busy != 0) d = bus.req_data[m_owner*W +: W];
      e.fa  = (m_busy != 0);
      e.fd  = (m_done != 0);
      e.gid = 2'(m_owner);
      e.av  = (m_busy != 0) && bus.req_valid[m_owner];
      e.rdy = ((m_busy != 0) && bus.agg_rdy) ? N'(1 << m_owner) : '0;
      e.dat = d;
      cyc_q.push_back(e);
      m_done = 0;
      if (m_busy != 0) begin
         if (e.av && bus.agg_rdy) begin
            beat_q.push_back({2'(m_owner), d});
            seq[m_owner]++;
            m_beats++;
            if (m_beats == FB) begin
               m_busy = 0;
               m_done = 1;
               m_ptr  = (m_owner + 1) % N;
            end
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            int s;
            s = (m_ptr + k) % N;
            if (bus.req_valid[s]) begin
               m_busy  = 1;
               m_owner = s;
               m_beats = 0;
               break;
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]         = v_mask[i] && ($urandom_range(99) < v_pct);
         bus.req_data[i*W +: W]   = {4'(i), 12'(seq[i])};
      end
      bus.agg_rdy = (rdy_force >= 0) ? rdy_force[0] : ($urandom_range(99) < r_pct);
      model_step();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_frame_active", 32'(frame_active), 0);
      chk("rst_frame_done",   32'(frame_done),   0);
      chk("rst_grant_id",     32'(grant_id),     0);
      chk("rst_req_rdy",      32'(bus.req_rdy),  0);
      chk("rst_agg_valid",    32'(bus.agg_valid), 0);
      chk("rst_agg_data",     32'(bus.agg_data), 0);
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.agg_rdy   = 1'b0;
      cyc_q.delete();
      beat_q.delete();
      m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0; m_done = 0;
      for (int i = 0; i < N; i++) seq[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      model_step();
   endtask

   initial begin
      cyc_t  a_c, e_c;
      beat_t a_b, e_b;
      int    cnt;

      v_mask = '0; v_pct = 100; r_pct = 100; rdy_force = -1;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.agg_rdy   = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (rst) begin
               a_c = {frame_active, frame_done, grant_id, bus.req_rdy, bus.agg_valid, bus.agg_data};
               total++;
               if (cyc_q.size() == 0) begin
                  bad++;
                  $display("FAIL cycle_expect: got=%h want=none t=%0t", a_c, $time);
               end else begin
                  e_c = cyc_q.pop_front();
                  if (a_c !== e_c) begin
                     bad++;
                     $display("FAIL cycle_outputs: got=%h want=%h t=%0t", a_c, e_c, $time);
                  end
               end
               if (bus.agg_valid && bus.agg_rdy) begin
                  a_b = {grant_id, bus.agg_data};
                  total++;
                  if (beat_q.size() == 0) begin
                     bad++;
                     $display("FAIL beat_expect: got=%h want=none t=%0t", a_b, $time);
                  end else begin
                     e_b = beat_q.pop_front();
                     if (a_b !== e_b) begin
                        bad++;
                        $display("FAIL beat_data: got=%h want=%h t=%0t", a_b, e_b, $time);
                     end
                  end
               end
               total++;
               if ($countones(bus.req_rdy) > 1) begin
                  bad++;
                  $display("FAIL rdy_onehot: got=%b want=at most one bit t=%0t", bus.req_rdy, $time);
               end
            end
         end
      join_none

      // Single source 2, no stalls.
      do_reset();
      v_mask = 4'b0100; v_pct = 100; rdy_force = 1;
      cycle();
      cycle();
      #3;
      chk("single_grant_c1", 32'(grant_id), 2);
      chk("single_active_c1", 32'(frame_active), 1);
      repeat (23) cycle();
      #3;
      chk("single_done_c24", 32'(frame_done), 1);
      chk("single_idle_c24", 32'(frame_active), 0);
      cycle();
      #3;
      chk("single_regrant_c25", {31'd0, frame_active} | (32'(grant_id) << 4), 32'h21);

      // Backpressure on source 1: stall after 5 accepted beats for 5 cycles.
      do_reset();
      v_mask = 4'b0010; rdy_force = 1;
      cycle();
      cnt = 0;
      for (int c = 0; c < 60; c++) begin
         rdy_force = (c >= 5 && c < 10) ? 0 : 1;
         cycle();
         #3;
         if (c == 7) chk("stall_req_rdy", 32'(bus.req_rdy), 0);
         if (frame_active) cnt++;
         else break;
      end
      chk("stall_xfer_cycles", 32'(cnt), 28);

      // Reset in the middle of source 1's frame, then sources 1 and 2 compete.
      rdy_force = 1;
      for (int c = 0; c < 60 && !(m_busy != 0 && m_owner == 1 && m_beats == 7); c++) cycle();
      do_reset();
      v_mask = 4'b0110;
      cycle();
      cycle();
      #3;
      chk("post_reset_grant", 32'(grant_id), 1);

      // Randomised phases: all four valid, wrap pair 3/0, sparse pairs, random masks.
      rdy_force = -1;
      for (int ph = 0; ph < 6; ph++) begin
         case (ph)
            0: begin do_reset(); v_mask = 4'hF; v_pct = 100; r_pct = 100; end
            1: begin v_mask = 4'b1001; v_pct = 100; r_pct = 100; end
            2: begin v_mask = 4'b1001; v_pct = 75;  r_pct = 70;  end
            3: begin v_mask = 4'b0101; v_pct = 85;  r_pct = 80;  end
            default: begin v_mask = 4'($urandom_range(15)); v_pct = $urandom_range(100, 50); r_pct = $urandom_range(100, 50); end
         endcase
         repeat (300) cycle();
      end

      @(negedge clk);
      #1;
      chk("cyc_q_drained", 32'(cyc_q.size()), 0);
      chk("beat_q_drained", 32'(beat_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
